// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM-stage data-bus controller: access sizes,
// FSM states, the latched request record and small size/lane helpers.
package cpu_pkg;

  // Access size encoding (store size and load size share it)
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Controller FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Request captured on leaving IDLE; drives the bus until the access retires
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  ld_size;
    logic        ld_uns;
  } mem_req_t;

  // Byte enables for a size at a byte offset; NONE falls through to word
  function automatic logic [3:0] size_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: size_be = 4'b0001 << off;
      SZ_HALF: size_be = 4'b0011 << off;
      default: size_be = 4'b1111;
    endcase
  endfunction

  // Natural-alignment fault; NONE is treated as word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it may land in
  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_rep = {4{d[7:0]}};
      SZ_HALF: store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module mem_load_align import cpu_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [3:0][7:0] lanes;
  logic [7:0]      b;
  logic [15:0]     h;

  assign lanes = word;
  assign b     = lanes[off];
  // Halves are naturally aligned, so only off[1] selects the upper pair
  assign h     = off[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

  // Extend the selected lane; unsigned loads force the fill bits to zero
  always_comb begin
    case (size)
      SZ_BYTE: data = {{24{b[7] & ~uns}}, b};
      SZ_HALF: data = {{16{h[15] & ~uns}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-bus controller. Turns a load/store in the MEM stage into a
// single req/gnt/rvalid bus transaction, stalling the pipeline until it
// retires. Misaligned accesses fault immediately and never reach the bus.
module mem_stage_ctrl import cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_mem_read_i,
  input  logic [1:0]  mem_mem_write_i,
  input  logic [1:0]  mem_ld_size_i,
  input  logic        mem_ld_uns_i,
  input  logic [31:0] mem_resC_i,
  input  logic [31:0] mem_rD2_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i
);

  logic [1:0]  state, state_nxt;
  mem_req_t    req_q;
  logic [31:0] rdata_q;
  logic [31:0] ld_data;
  logic        is_write, access, bad_align, take;
  logic [1:0]  acc_size;

  // A store wins over a simultaneous load
  assign is_write  = (mem_mem_write_i != SZ_NONE);
  assign access    = is_write | mem_mem_read_i;
  assign acc_size  = is_write ? mem_mem_write_i : mem_ld_size_i;
  assign bad_align = misaligned(acc_size, mem_resC_i[1:0]);
  assign take      = (state == S_IDLE) && access && !bad_align;

  // Next-state: IDLE -> REQ -> (WAIT for loads) -> DONE -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = S_REQ;
      S_REQ:   if (dbus_gnt_i) state_nxt = req_q.we ? S_DONE : S_WAIT;
      S_WAIT:  if (dbus_rvalid_i) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture the request on acceptance so bus outputs stay stable until gnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (take) begin
      req_q.addr    <= mem_resC_i;
      req_q.we      <= is_write;
      req_q.be      <= size_be(acc_size, mem_resC_i[1:0]);
      req_q.wdata   <= is_write ? store_rep(mem_mem_write_i, mem_rD2_i) : '0;
      req_q.ld_size <= mem_ld_size_i;
      req_q.ld_uns  <= mem_ld_uns_i;
    end
  end

  mem_load_align u_align (
    .word (dbus_rdata_i),
    .off  (req_q.addr[1:0]),
    .size (req_q.ld_size),
    .uns  (req_q.ld_uns),
    .data (ld_data)
  );

  // Load result register; holds its value until the next load returns.
  // Only WAIT accepts rvalid, so a response stranded by reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              rdata_q <= '0;
    else if (state == S_WAIT && dbus_rvalid_i) rdata_q <= ld_data;
  end

  assign stall_o       = (state == S_REQ) || (state == S_WAIT) || take;
  assign misalign_o    = (state == S_IDLE) && access && bad_align;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state == S_DONE) && !req_q.we;

  assign dbus_req_o    = (state == S_REQ);
  assign dbus_we_o     = req_q.we;
  assign dbus_addr_o   = {req_q.addr[31:2], 2'b00};
  assign dbus_be_o     = req_q.be;
  assign dbus_wdata_o  = req_q.wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed transactions with a timeline model of
// stall/req/valid built from gnt/rvalid delays, arithmetic lane/extension
// model, and a per-cycle compare process.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_mem_read_i;
  logic [1:0]  mem_mem_write_i;
  logic [1:0]  mem_ld_size_i;
  logic        mem_ld_uns_i;
  logic [31:0] mem_resC_i;
  logic [31:0] mem_rD2_i;
  logic        stall_o, misalign_o, rdata_valid_o;
  logic [31:0] rdata_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  mem_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_mem_read_i(mem_mem_read_i), .mem_mem_write_i(mem_mem_write_i),
    .mem_ld_size_i(mem_ld_size_i), .mem_ld_uns_i(mem_ld_uns_i),
    .mem_resC_i(mem_resC_i), .mem_rD2_i(mem_rD2_i),
    .stall_o(stall_o), .misalign_o(misalign_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model expectations for the current cycle
  bit          chk_en = 1'b0;
  logic        e_stall, e_req, e_mis, e_valid, e_we;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0]  e_be;

  // Per-transaction observations for the literal pins
  int          n_stall, n_req, n_valid, n_mis;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_be;
  logic        obs_we;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare DUT against model every sampled cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall_o}, {31'd0, e_stall});
      chk("dbus_req", {31'd0, dbus_req_o}, {31'd0, e_req});
      chk("misalign", {31'd0, misalign_o}, {31'd0, e_mis});
      chk("rdata_valid", {31'd0, rdata_valid_o}, {31'd0, e_valid});
      chk("rdata", rdata_o, e_rdata);
      if (e_req) begin
        chk("addr", dbus_addr_o, e_addr);
        chk("we", {31'd0, dbus_we_o}, {31'd0, e_we});
        chk("be", {28'd0, dbus_be_o}, {28'd0, e_be});
        if (e_we) chk("wdata", dbus_wdata_o, e_wd);
      end
      if (dbus_req_o) begin
        n_req++;
        obs_addr = dbus_addr_o; obs_be = dbus_be_o; obs_wd = dbus_wdata_o; obs_we = dbus_we_o;
      end
      if (stall_o)       n_stall++;
      if (rdata_valid_o) n_valid++;
      if (misalign_o)    n_mis++;
    end
  end

  task automatic idle_inputs();
    mem_mem_read_i = 1'b0; mem_mem_write_i = 2'b00; mem_ld_size_i = 2'b00;
    mem_ld_uns_i = 1'b0; mem_resC_i = '0; mem_rD2_i = '0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
    e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_valid = 1'b0;
  endtask

  task automatic clr_obs();
    n_stall = 0; n_req = 0; n_valid = 0; n_mis = 0;
    obs_addr = '0; obs_be = '0; obs_wd = '0; obs_we = 1'b0;
  endtask

  // One MEM-stage access. gd = REQ cycles before the gnt cycle,
  // rdl = cycles from gnt to rvalid (>=1), rw = word returned by the bus.
  task automatic txn(input logic [1:0] wsz, input bit rd, input logic [1:0] lsz, input bit uns,
                     input logic [31:0] a, input logic [31:0] d, input int gd, input int rdl,
                     input logic [31:0] rw);
    bit          wr, mis;
    int          nb, off, n;
    logic [1:0]  s;
    logic [31:0] lane, ld, be_m, wd;
    wr   = (wsz != 2'b00);
    s    = wr ? wsz : ((lsz == 2'b00) ? 2'b11 : lsz);
    nb   = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
    off  = int'(a[1:0]);
    mis  = (off % nb) != 0;
    be_m = ((32'd1 << nb) - 32'd1) << off;
    wd   = (nb == 1) ? d[7:0] * 32'h01010101 : (nb == 2) ? d[15:0] * 32'h00010001 : d;
    lane = rw >> (8 * off);
    if (nb == 4) ld = rw;
    else begin
      lane = lane & ((32'd1 << (8 * nb)) - 32'd1);
      ld   = (!uns && lane[8 * nb - 1]) ? lane - (32'd1 << (8 * nb)) : lane;
    end
    n = mis ? 1 : (wr ? gd + 3 : gd + rdl + 3);
    clr_obs();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      mem_mem_write_i = wsz; mem_mem_read_i = rd; mem_ld_size_i = lsz;
      mem_ld_uns_i = uns; mem_resC_i = a; mem_rD2_i = d;
      dbus_gnt_i    = !mis && (k == gd + 1);
      dbus_rvalid_i = !mis && !wr && (k == gd + 1 + rdl);
      dbus_rdata_i  = dbus_rvalid_i ? rw : $urandom;
      e_stall = !mis && (k < n - 1);
      e_req   = !mis && (k >= 1) && (k <= gd + 1);
      e_mis   = mis && (k == 0);
      e_valid = !mis && !wr && (k == n - 1);
      if (e_valid) e_rdata = ld;
      e_addr = {a[31:2], 2'b00}; e_be = be_m[3:0]; e_wd = wd; e_we = wr;
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    e_rdata = '0; e_addr = '0; e_be = '0; e_wd = '0; e_we = 1'b0;
    clr_obs();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store 0xDEADBEEF @0x100, immediate gnt
    txn(2'b11, 1'b0, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
    chk("ws_addr", obs_addr, 32'h100);
    chk("ws_be", {28'd0, obs_be}, 32'hF);
    chk("ws_we", {31'd0, obs_we}, 32'd1);
    chk("ws_stall_cycles", n_stall, 2);

    // Byte load @0x203, signed then unsigned
    txn(2'b00, 1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 0, 1, 32'h80112233);
    chk("lb_signed", rdata_o, 32'hFFFFFF80);
    chk("lb_valid_cycles", n_valid, 1);
    txn(2'b00, 1'b1, 2'b01, 1'b1, 32'h203, 32'h0, 0, 1, 32'h80112233);
    chk("lb_unsigned", rdata_o, 32'h00000080);

    // Half store 0x1234 @0x102
    txn(2'b10, 1'b0, 2'b00, 1'b0, 32'h102, 32'h00001234, 0, 1, 32'h0);
    chk("hs_be", {28'd0, obs_be}, 32'hC);
    chk("hs_wdata", obs_wd, 32'h12341234);

    // Misaligned word load @0x101
    txn(2'b00, 1'b1, 2'b11, 1'b0, 32'h101, 32'h0, 0, 1, 32'h0);
    chk("mis_pulses", n_mis, 1);
    chk("mis_reqs", n_req, 0);
    chk("mis_stall", n_stall, 0);

    // Slow bus: gnt after 3 waiting cycles, rvalid 2 cycles after gnt
    txn(2'b00, 1'b1, 2'b11, 1'b0, 32'h300, 32'h0, 3, 2, 32'hCAFEF00D);
    chk("slow_req_cycles", n_req, 4);
    chk("slow_stall_cycles", n_stall, 7);
    chk("slow_valid_cycles", n_valid, 1);
    chk("slow_rdata", rdata_o, 32'hCAFEF00D);

    // Extra patterns: signed upper half, byte store lane 1, size-00 load,
    // write+read collision, misaligned half store
    txn(2'b00, 1'b1, 2'b10, 1'b0, 32'h202, 32'h0, 1, 1, 32'h80017FFF);
    chk("lh_signed", rdata_o, 32'hFFFF8001);
    txn(2'b01, 1'b0, 2'b00, 1'b0, 32'h401, 32'h000000AB, 2, 1, 32'h0);
    chk("sb_be", {28'd0, obs_be}, 32'h2);
    chk("sb_wdata", obs_wd, 32'hABABABAB);
    txn(2'b00, 1'b1, 2'b00, 1'b1, 32'h500, 32'h0, 0, 3, 32'h89ABCDEF);
    chk("lw_size00", rdata_o, 32'h89ABCDEF);
    txn(2'b11, 1'b1, 2'b01, 1'b0, 32'h600, 32'h55AA55AA, 0, 1, 32'h0);
    chk("wr_wins_we", {31'd0, obs_we}, 32'd1);
    chk("wr_wins_valid", n_valid, 0);
    txn(2'b10, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0000BEEF, 0, 1, 32'h0);
    chk("hs_mis_pulses", n_mis, 1);

    // Reset while WAITing; the stranded rvalid must be ignored
    clr_obs();
    @(posedge clk); #1;
    mem_mem_read_i = 1'b1; mem_ld_size_i = 2'b11; mem_resC_i = 32'h700;
    e_stall = 1'b1; e_req = 1'b0; e_addr = 32'h700; e_be = 4'hF; e_we = 1'b0;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b1; e_req = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0; e_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    e_rdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    dbus_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_cycles", n_valid, 0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_req_cycles", n_req, 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_mem_read_i  in  1  load request, MEM stage
- mem_mem_write_i  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- mem_ld_size_i  in  2  load size, same encoding; 00 treated as word
- mem_ld_uns_i  in  1  1 = zero-extend load, 0 = sign-extend
- mem_resC_i  in  32  byte address
- mem_rD2_i  in  32  store data, right-aligned
- stall_o  out  1  freeze IF..EX/MEM pipeline registers
- misalign_o  out  1  one-cycle alignment-fault pulse
- rdata_o  out  32  extended load result
- rdata_valid_o  out  1  rdata_o valid this cycle
- dbus_req_o  out  1  bus request, held until dbus_gnt_i
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word address, bits [1:0] = 00
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  read data valid; never earlier than 1 cycle after gnt
- dbus_rdata_i  in  32  read word
REQ-002 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-004 Access SHALL be defined as (mem_mem_write_i != 00) or mem_mem_read_i; if both are set, the write SHALL win and the read SHALL be ignored.
REQ-005 An access SHALL be misaligned when half has addr[0] = 1 or word has addr[1:0] != 00; misaligned accesses SHALL produce no bus activity, misalign_o = 1 in that cycle, stall_o = 0, state remains IDLE.
REQ-006 IDLE with an aligned access SHALL go to REQ, latching addr, we, be, wdata, load size/sign.
REQ-007 dbus_req_o SHALL be 1 exactly in REQ; bus outputs SHALL remain stable until gnt.
REQ-008 REQ with gnt: write SHALL go to DONE; read SHALL go to WAIT.
REQ-009 WAIT with dbus_rvalid_i SHALL go to DONE, capturing the extended result into rdata_o.
REQ-010 DONE SHALL last one cycle with rdata_valid_o = 1 for reads, then return to IDLE.
REQ-011 stall_o SHALL be combinational: 1 in REQ and WAIT, and in IDLE with an aligned access pending; 0 in DONE.
REQ-012 Minimum latency SHALL be: write 3 cycles (IDLE, REQ+gnt, DONE); read 4 cycles.
REQ-013 Byte enables: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; loads SHALL also drive be per size.
REQ-014 Write data: byte replicated x4, half replicated x2, word unchanged.
REQ-015 Load extraction SHALL select the lane by addr[1:0] and extend it to 32 bits per mem_ld_uns_i.
REQ-016 rdata_o SHALL hold its last value outside DONE.

Reset
REQ-017 Asserting rst_n low SHALL force IDLE and clear dbus_req_o, rdata_valid_o, misalign_o, rdata_o and the latched request registers to 0, including mid-transaction; an outstanding rvalid after reset SHALL be ignored.

Structure
REQ-018 Size encodings and the FSM state enumeration SHALL live in the shared package cpu_pkg.
REQ-019 Lane extraction and extension SHALL be one combinational sub-module, mem_load_align.

Verification
REQ-020 Word store 0xDEADBEEF @0x100, gnt in the first REQ cycle -> addr 0x100, be 1111, we 1, stall 1 for 2 cycles, then 0.
REQ-021 Byte load @0x203, rdata 0x80112233, signed -> rdata_o 0xFFFFFF80, rdata_valid_o 1 for one cycle; unsigned -> 0x00000080.
REQ-022 Half store 0x1234 @0x102 -> be 1100, wdata 0x12341234.
REQ-023 Word load @0x101 -> misalign_o pulse, no dbus_req_o, stall_o 0.
REQ-024 Read with gnt delayed 3 cycles and rvalid after 2 more -> stall_o held throughout, req stable, single DONE.
REQ-025 rst_n low in WAIT -> IDLE, dbus_req_o 0; a late rvalid produces no rdata_valid_o.
